// File: rtl/mem_arbiter.sv
// Merges instruction-read and data read/write ports onto one single-ported memory bus.
// Define MEM_ARB_RR_EN to round-robin between the instruction and data classes.
module mem_arbiter #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_re,
   input  logic [XLEN-1:0]   i_addr,
   output logic [XLEN-1:0]   i_rdata,
   output logic              i_ack,
   input  logic              d_re,
   input  logic [XLEN-1:0]   d_raddr,
   output logic [XLEN-1:0]   d_rdata,
   output logic              d_rack,
   input  logic              d_we,
   input  logic [XLEN-1:0]   d_waddr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [XLEN/8-1:0] d_wmask,
   output logic              d_wack,
   output logic              m_req,
   output logic              m_we,
   output logic [XLEN-1:0]   m_addr,
   output logic [XLEN-1:0]   m_wdata,
   output logic [XLEN/8-1:0] m_wmask,
   input  logic [XLEN-1:0]   m_rdata,
   input  logic              m_ack
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
   typedef enum logic [1:0] {GNT_I, GNT_DR, GNT_DW} grant_t;

   state_t            state_q, state_d;
   grant_t            grant_q, grant_d, sel_gnt;
   logic              any_req;
   logic              m_req_q, m_req_d;
   logic              m_we_q, m_we_d;
   logic [XLEN-1:0]   m_addr_q, m_addr_d;
   logic [XLEN-1:0]   m_wdata_q, m_wdata_d;
   logic [XLEN/8-1:0] m_wmask_q, m_wmask_d;
   logic              i_ack_q, i_ack_d;
   logic              d_rack_q, d_rack_d;
   logic              d_wack_q, d_wack_d;
   logic [XLEN-1:0]   i_rdata_q, i_rdata_d;
   logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
   logic [3:0]        starve_q, starve_d;
`ifdef MEM_ARB_RR_EN
   logic              last_data_q, last_data_d;
`endif

   assign any_req = i_re | d_re | d_we;

   always_comb begin
      if (d_we)      sel_gnt = GNT_DW;
      else if (d_re) sel_gnt = GNT_DR;
      else           sel_gnt = GNT_I;
`ifdef MEM_ARB_RR_EN
      // Data class won the previous grant: a pending fetch goes ahead of it.
      if (i_re && last_data_q) sel_gnt = GNT_I;
`endif
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wmask_d = m_wmask_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      starve_d  = starve_q;
      i_ack_d   = 1'b0;
      d_rack_d  = 1'b0;
      d_wack_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_data_d = last_data_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d   = ST_BUSY;
               grant_d   = sel_gnt;
               m_req_d   = 1'b1;
               m_we_d    = (sel_gnt == GNT_DW);
               m_addr_d  = (sel_gnt == GNT_DW) ? d_waddr :
                           (sel_gnt == GNT_DR) ? d_raddr : i_addr;
               m_wdata_d = (sel_gnt == GNT_DW) ? d_wdata : '0;
               m_wmask_d = (sel_gnt == GNT_DW) ? d_wmask : '1;
               if (i_re && (sel_gnt != GNT_I) && (starve_q != 4'hF))
                  starve_d = starve_q + 4'd1;
`ifdef MEM_ARB_RR_EN
               last_data_d = (sel_gnt != GNT_I);
`endif
            end
         end
         ST_BUSY: begin
            if (m_ack) begin
               state_d = ST_RESP;
               m_req_d = 1'b0;
               case (grant_q)
                  GNT_I: begin
                     i_rdata_d = m_rdata;
                     i_ack_d   = 1'b1;
                     starve_d  = '0;
                  end
                  GNT_DR: begin
                     d_rdata_d = m_rdata;
                     d_rack_d  = 1'b1;
                  end
                  default: d_wack_d = 1'b1;
               endcase
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= GNT_I;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wmask_q <= '0;
         i_ack_q   <= 1'b0;
         d_rack_q  <= 1'b0;
         d_wack_q  <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         starve_q  <= '0;
`ifdef MEM_ARB_RR_EN
         last_data_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wmask_q <= m_wmask_d;
         i_ack_q   <= i_ack_d;
         d_rack_q  <= d_rack_d;
         d_wack_q  <= d_wack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         starve_q  <= starve_d;
`ifdef MEM_ARB_RR_EN
         last_data_q <= last_data_d;
`endif
      end
   end

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wmask = m_wmask_q;
   assign i_ack   = i_ack_q;
   assign d_rack  = d_rack_q;
   assign d_wack  = d_wack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a wait-state-programmable memory responder.
module tb_mem_arbiter;
   localparam int XLEN = 32;

   logic              clk;
   logic              reset;
   logic              i_re, d_re, d_we;
   logic [XLEN-1:0]   i_addr, d_raddr, d_waddr, d_wdata;
   logic [XLEN/8-1:0] d_wmask;
   logic [XLEN-1:0]   i_rdata, d_rdata;
   logic              i_ack, d_rack, d_wack;
   logic              m_req, m_we, m_ack;
   logic [XLEN-1:0]   m_addr, m_wdata, m_rdata;
   logic [XLEN/8-1:0] m_wmask;

   int checks;
   int errors;
   int mem_wait   = 0;
   bit inject_req = 1'b0;

   typedef struct {
      logic [2:0]  ack;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic [2:0]  ack;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          req_cycles;
      bit          unstable;
      bit          timeout;
   } obs_t;

   exp_t exp_q[$];

   mem_arbiter #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_re(d_re), .d_raddr(d_raddr), .d_rdata(d_rdata), .d_rack(d_rack),
      .d_we(d_we), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wmask(d_wmask), .d_wack(d_wack),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
      .m_rdata(m_rdata), .m_ack(m_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic exp_t mk_exp(input logic [2:0] ack, input logic [31:0] addr, input logic we,
                                   input logic [31:0] wdata, input logic [3:0] wmask);
      exp_t e;
      e.ack   = ack;
      e.addr  = addr;
      e.we    = we;
      e.wdata = wdata;
      e.wmask = wmask;
      e.rdata = we ? 32'h0 : mem_val(addr);
      return e;
   endfunction

   // Memory: acks after mem_wait extra BUSY cycles; a toggle of inject_req forces a stray ack.
   initial begin : responder
      int wait_cnt;
      bit inject_seen;
      wait_cnt    = 0;
      inject_seen = 1'b0;
      m_ack       = 1'b0;
      m_rdata     = '0;
      forever begin
         @(posedge clk);
         #1;
         m_ack = 1'b0;
         if (inject_req != inject_seen) begin
            inject_seen = inject_req;
            m_ack       = 1'b1;
            m_rdata     = 32'hBAD0_BAD0;
         end else if (m_req) begin
            if (wait_cnt >= mem_wait) begin
               m_ack    = 1'b1;
               m_rdata  = mem_val(m_addr);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic wait_ack(output obs_t o);
      bit seen;
      seen         = 1'b0;
      o.ack        = '0;
      o.addr       = '0;
      o.we         = 1'b0;
      o.wdata      = '0;
      o.wmask      = '0;
      o.req_cycles = 0;
      o.unstable   = 1'b0;
      o.timeout    = 1'b1;
      for (int c = 0; c < 200 && o.timeout; c++) begin
         @(negedge clk);
         if (m_req === 1'b1) begin
            if (!seen) begin
               o.addr  = m_addr;
               o.we    = m_we;
               o.wdata = m_wdata;
               o.wmask = m_wmask;
               seen    = 1'b1;
            end else if ({m_addr, m_we, m_wdata, m_wmask} !== {o.addr, o.we, o.wdata, o.wmask}) begin
               o.unstable = 1'b1;
            end
            o.req_cycles++;
         end
         if ((i_ack | d_rack | d_wack) === 1'b1) begin
            o.ack     = {i_ack, d_rack, d_wack};
            o.timeout = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({m_req, m_we, m_addr, m_wdata, m_wmask, i_ack, d_rack, d_wack, i_rdata, d_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {m_req, m_we, m_addr, m_wdata, m_wmask, i_ack, d_rack, d_wack, i_rdata, d_rdata});
      end
      reset = 1'b0;
   endtask

   task automatic test_zero_wait();
      exp_t e;
      mem_wait = 0;
      exp_q.push_back(mk_exp(3'b100, 32'h100, 1'b0, 32'h0, 4'hF));
      @(negedge clk);
      i_re   = 1'b1;
      i_addr = 32'h100;
      @(negedge clk);
      checks++;
      if ({m_req, m_we, m_addr, m_wmask} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
         errors++;
         $display("FAIL zw_req_cycle1: got req=%b we=%b addr=%h mask=%h required req=1 we=0 addr=100 mask=f",
                  m_req, m_we, m_addr, m_wmask);
      end
      checks++;
      if ({i_ack, d_rack, d_wack} !== 3'b000) begin
         errors++;
         $display("FAIL zw_early_ack: got %b required 000", {i_ack, d_rack, d_wack});
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({i_ack, d_rack, d_wack} !== e.ack) begin
         errors++;
         $display("FAIL zw_ack_cycle2: got %b required %b", {i_ack, d_rack, d_wack}, e.ack);
      end
      checks++;
      if (i_rdata !== e.rdata) begin
         errors++;
         $display("FAIL zw_rdata: got %h required %h", i_rdata, e.rdata);
      end
      i_re = 1'b0;
   endtask

   task automatic test_wait_write();
      exp_t e;
      obs_t o;
      mem_wait = 2;
      exp_q.push_back(mk_exp(3'b001, 32'h2004, 1'b1, 32'hDEAD_BEEF, 4'b0011));
      @(negedge clk);
      d_we    = 1'b1;
      d_waddr = 32'h2004;
      d_wdata = 32'hDEAD_BEEF;
      d_wmask = 4'b0011;
      wait_ack(o);
      e = exp_q.pop_front();
      checks++;
      if (o.timeout || o.ack !== e.ack) begin
         errors++;
         $display("FAIL ww_ack: got %b (timeout=%0d) required %b", o.ack, o.timeout, e.ack);
      end
      checks++;
      if ({o.we, o.addr, o.wdata, o.wmask} !== {e.we, e.addr, e.wdata, e.wmask}) begin
         errors++;
         $display("FAIL ww_bus: got we=%b addr=%h data=%h mask=%b required we=%b addr=%h data=%h mask=%b",
                  o.we, o.addr, o.wdata, o.wmask, e.we, e.addr, e.wdata, e.wmask);
      end
      checks++;
      if (o.req_cycles != 3 || o.unstable) begin
         errors++;
         $display("FAIL ww_req_hold: got %0d cycles unstable=%0d required 3 cycles stable",
                  o.req_cycles, o.unstable);
      end
      d_we     = 1'b0;
      mem_wait = 0;
   endtask

   task automatic test_simultaneous();
      exp_t e;
      obs_t o;
      mem_wait = 1;
`ifdef MEM_ARB_RR_EN
      exp_q.push_back(mk_exp(3'b100, 32'h104, 1'b0, 32'h0, 4'hF));
      exp_q.push_back(mk_exp(3'b001, 32'h3000, 1'b1, 32'h1122_3344, 4'b1100));
      exp_q.push_back(mk_exp(3'b010, 32'h3008, 1'b0, 32'h0, 4'hF));
`else
      exp_q.push_back(mk_exp(3'b001, 32'h3000, 1'b1, 32'h1122_3344, 4'b1100));
      exp_q.push_back(mk_exp(3'b010, 32'h3008, 1'b0, 32'h0, 4'hF));
      exp_q.push_back(mk_exp(3'b100, 32'h104, 1'b0, 32'h0, 4'hF));
`endif
      @(negedge clk);
      i_re    = 1'b1;
      i_addr  = 32'h104;
      d_re    = 1'b1;
      d_raddr = 32'h3008;
      d_we    = 1'b1;
      d_waddr = 32'h3000;
      d_wdata = 32'h1122_3344;
      d_wmask = 4'b1100;
      for (int t = 0; t < 3; t++) begin
         wait_ack(o);
         e = exp_q.pop_front();
         checks++;
         if (o.timeout || o.ack !== e.ack) begin
            errors++;
            $display("FAIL sim_ack[%0d]: got %b (timeout=%0d) required %b", t, o.ack, o.timeout, e.ack);
         end
         checks++;
         if ({o.we, o.addr, o.wmask} !== {e.we, e.addr, e.wmask}) begin
            errors++;
            $display("FAIL sim_bus[%0d]: got we=%b addr=%h mask=%b required we=%b addr=%h mask=%b",
                     t, o.we, o.addr, o.wmask, e.we, e.addr, e.wmask);
         end
         checks++;
         if (e.ack[2] && i_rdata !== e.rdata) begin
            errors++;
            $display("FAIL sim_irdata[%0d]: got %h required %h", t, i_rdata, e.rdata);
         end else if (e.ack[1] && d_rdata !== e.rdata) begin
            errors++;
            $display("FAIL sim_drdata[%0d]: got %h required %h", t, d_rdata, e.rdata);
         end else if (e.ack[0] && o.wdata !== e.wdata) begin
            errors++;
            $display("FAIL sim_wdata[%0d]: got %h required %h", t, o.wdata, e.wdata);
         end
         if (o.timeout || o.ack[2]) i_re = 1'b0;
         if (o.timeout || o.ack[1]) d_re = 1'b0;
         if (o.timeout || o.ack[0]) d_we = 1'b0;
      end
      mem_wait = 0;
   endtask

   task automatic test_busy_change();
      exp_t e;
      obs_t o;
      bit   found;
      mem_wait = 2;
      exp_q.push_back(mk_exp(3'b010, 32'h40, 1'b0, 32'h0, 4'hF));
      @(negedge clk);
      d_re    = 1'b1;
      d_raddr = 32'h40;
      found   = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (m_req === 1'b1) found = 1'b1;
      end
      d_raddr = 32'h80;
      wait_ack(o);
      e = exp_q.pop_front();
      checks++;
      if (!found || o.timeout || o.ack !== e.ack) begin
         errors++;
         $display("FAIL busy_ack: got %b (req_seen=%0d timeout=%0d) required %b", o.ack, found, o.timeout, e.ack);
      end
      checks++;
      if (o.addr !== e.addr || o.unstable) begin
         errors++;
         $display("FAIL busy_addr: got %h unstable=%0d required %h stable", o.addr, o.unstable, e.addr);
      end
      checks++;
      if (d_rdata !== e.rdata) begin
         errors++;
         $display("FAIL busy_rdata: got %h required %h", d_rdata, e.rdata);
      end
      d_re     = 1'b0;
      mem_wait = 0;
   endtask

   task automatic test_starvation();
      obs_t        o;
      logic [2:0]  want;
      logic [31:0] daddr;
      bit          i_pend, last_data, grant_i;
      int          starve_m, i_done_at;
      daddr     = 32'h1000;
      i_pend    = 1'b1;
      last_data = 1'b1;
      starve_m  = 0;
      i_done_at = -1;
      @(negedge clk);
      i_re    = 1'b1;
      i_addr  = 32'h500;
      d_re    = 1'b1;
      d_raddr = daddr;
      for (int k = 0; k < 20; k++) begin
         grant_i = 1'b0;
`ifdef MEM_ARB_RR_EN
         grant_i = i_pend && last_data;
`endif
         if (grant_i) starve_m = 0;
         else if (i_pend && starve_m < 15) starve_m++;
         last_data = !grant_i;
         want = grant_i ? 3'b100 : 3'b010;
         wait_ack(o);
         checks++;
         if (o.timeout || o.ack !== want) begin
            errors++;
            $display("FAIL starve_ack[%0d]: got %b (timeout=%0d) required %b", k, o.ack, o.timeout, want);
         end
         checks++;
         if (grant_i && i_rdata !== mem_val(32'h500)) begin
            errors++;
            $display("FAIL starve_irdata[%0d]: got %h required %h", k, i_rdata, mem_val(32'h500));
         end else if (!grant_i && d_rdata !== mem_val(daddr)) begin
            errors++;
            $display("FAIL starve_drdata[%0d]: got %h required %h", k, d_rdata, mem_val(daddr));
         end
         checks++;
         if (dut.starve_q !== starve_m[3:0]) begin
            errors++;
            $display("FAIL starve_cnt[%0d]: got %0d required %0d", k, dut.starve_q, starve_m);
         end
         if (grant_i) begin
            i_re      = 1'b0;
            i_pend    = 1'b0;
            i_done_at = k;
         end else begin
            d_re = 1'b0;
            @(negedge clk);
            if (k < 19) begin
               daddr   = daddr + 32'd4;
               d_raddr = daddr;
               d_re    = 1'b1;
            end
         end
      end
`ifdef MEM_ARB_RR_EN
      checks++;
      if (i_done_at < 0 || i_done_at > 1) begin
         errors++;
         $display("FAIL starve_rr_fetch: got i_ack at transaction %0d required within 2", i_done_at);
      end
`else
      wait_ack(o);
      checks++;
      if (o.timeout || o.ack !== 3'b100 || i_done_at != -1) begin
         errors++;
         $display("FAIL starve_final_fetch: got %b (timeout=%0d early=%0d) required 100", o.ack, o.timeout, i_done_at);
      end
      checks++;
      if (i_rdata !== mem_val(32'h500) || dut.starve_q !== 4'd0) begin
         errors++;
         $display("FAIL starve_clear: got rdata=%h cnt=%0d required rdata=%h cnt=0",
                  i_rdata, dut.starve_q, mem_val(32'h500));
      end
      i_re = 1'b0;
`endif
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit found;
      mem_wait = 100;
      @(negedge clk);
      d_re    = 1'b1;
      d_raddr = 32'h300;
      found   = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (m_req === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_mid_req: got no m_req required m_req before reset");
      end
      reset = 1'b1;
      d_re  = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_req, m_we, m_addr, m_wdata, m_wmask, i_ack, d_rack, d_wack, i_rdata, d_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %h required 0",
                  {m_req, m_we, m_addr, m_wdata, m_wmask, i_ack, d_rack, d_wack, i_rdata, d_rdata});
      end
      reset      = 1'b0;
      inject_req = !inject_req;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({m_req, i_ack, d_rack, d_wack} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_quiet[%0d]: got req/acks %b required 0000", c, {m_req, i_ack, d_rack, d_wack});
         end
      end
      mem_wait = 0;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      i_re    = 1'b0;
      d_re    = 1'b0;
      d_we    = 1'b0;
      i_addr  = '0;
      d_raddr = '0;
      d_waddr = '0;
      d_wdata = '0;
      d_wmask = '0;
      test_reset();
      test_zero_wait();
      test_wait_write();
      test_simultaneous();
      test_busy_change();
      test_starvation();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no completion required finish");
      $fatal(1);
   end

endmodule
